ocra1_word_scheduler: RTL and testbench
=======================================

Name: ocra1_word_scheduler

Overview:
- Sits directly upstream of the OCRA1 SPI serialiser; buffers 32-bit gradient words from the BRAM readout core and issues them as single-cycle valid pulses.
- Word format: bits 26:25 are the channel (0=x, 1=y, 2=z, 3=z2); bit 24 is broadcast; bits 23:0 are the DAC payload.
- Enforces the serialiser's timing rules. A broadcast is only issued while the serialiser is idle. No word is issued in the hold-off window after a broadcast, because the serialiser would drop it.
- Optionally stalls a second write to a channel that is still pending, so the serialiser never raises data-lost.

Parameters:
- DEPTH, 8, FIFO depth in words; power of two, minimum 2.
- HOLDOFF, 4, number of cycles after a broadcast issue during which valid_o is forced low; minimum 3.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- in_data_i  in  32  word from the BRAM readout.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  equals ~full & ~rst; a word is accepted on a clock edge where in_valid_i & in_ready_o.
- flush_i  in  1  synchronous; drops all queued words.
- busy_i  in  1  serialiser busy flag.
- data_o  out  32  issued word, registered.
- valid_o  out  1  issue strobe, high for exactly 1 cycle per word, registered.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- idle_o  out  1  high when the FIFO is empty, state is RUN and valid_o is low.

Behaviour:
- Reset (async assert, sync release) clears FIFO pointers, sets level_o=0, data_o=0, valid_o=0, state=RUN and pending mask=0.
- FIFO:
  - Simultaneous push and pop leaves level_o unchanged.
  - No push occurs when full, because ready is low.
  - Pointers wrap modulo DEPTH, with an extra MSB to distinguish full from empty.
- Latency: a word accepted at edge N into an empty FIFO in state RUN drives valid_o high from edge N+2.
- FSM states: RUN, HOLD.
  - RUN, head present, head is a channel write (bit24=0): issue if the issue condition holds; pop, register data_o, valid_o=1.
  - RUN, head is a broadcast (bit24=1): issue only if busy_i==0 and the issue condition holds. On issue, load hold counter=HOLDOFF-1, clear pending mask, go to HOLD.
  - HOLD: valid_o=0. Decrement the counter and go to RUN when it reaches 0. busy_i is ignored in HOLD.
- Issue condition is always true without the optional feature.
- Back-to-back channel writes may issue on consecutive cycles.
- Channel writes during an active transfer (busy_i=1) are permitted.
- flush_i:
  - Empties the FIFO in the same cycle, overriding any pop or push. in_ready_o still applies, but the pushed word is discarded.
  - Cancels any issue in that cycle; valid_o=0 on the next edge.
  - The hold counter keeps running, because the serialiser is mid-accept.
  - Clears the pending mask.
- Reset mid-HOLD aborts the hold; the next broadcast still waits for busy_i low.

Optional Feature:
- Macro OCRA1_SCHED_CONFLICT_EN.
- When defined:
  - A 4-bit pending mask sets bit[ch] on issue of any word, including broadcasts.
  - The mask clears on broadcast issue; a broadcast's own channel is then cleared, not set.
  - The issue condition becomes pending[head ch]==0; the head stalls otherwise.
  - An extra output, conflict_o (1 bit, registered), is high during every cycle stalled for this reason.
- When undefined: no mask, no conflict_o, and words issue regardless of the data-lost risk.

Decomposition:
- Package ocra1_pkg holds:
  - field constants CH_MSB=26, CH_LSB=25, BCAST_BIT=24, PAYLOAD_W=24;
  - a channel enum (CH_X, CH_Y, CH_Z, CH_Z2);
  - a state enum (RUN, HOLD).
- One sub-module, ocra1_sched_fifo: synchronous FIFO with push, pop, flush, level, full and empty. It has no output register; the head is combinational.

Test Plan:
- 3 writes (x=0x000100, y=0x000200, z=0x000300) pushed on consecutive cycles into an empty FIFO, busy_i=0 -> valid_o high for 3 consecutive cycles starting 2 edges after the first push, data_o in order.
- Broadcast word 0x01000055 with busy_i=1 for 20 cycles -> no issue until 1 cycle after busy_i falls, then valid_o=1, then valid_o=0 for 4 cycles (HOLD).
- Broadcast followed immediately by an x write -> gap of exactly HOLDOFF=4 cycles between the two valid_o pulses.
- Push 9 words with no pops (busy_i=1, all broadcast) -> in_ready_o=0 after 8 accepted, level_o=8; 9th accepted only after the first pop.
- flush_i with level_o=5 during HOLD -> level_o=0 the next cycle, HOLD still lasts its full count, then idle_o=1.
- With OCRA1_SCHED_CONFLICT_EN, two x writes then a broadcast -> second x stalls with conflict_o=1; the broadcast behind it is blocked, i.e. deadlock is expected. Bench checks conflict_o persists, then flush_i recovers to idle_o=1. Also: x, broadcast(y), x -> all issue, no conflict.

Source files
------------

// File: rtl/ocra1_pkg.sv
// Shared field layout, channel and state types for the OCRA1 word scheduler.
package ocra1_pkg;

  localparam int CH_MSB    = 26;
  localparam int CH_LSB    = 25;
  localparam int BCAST_BIT = 24;
  localparam int PAYLOAD_W = 24;

  typedef enum logic [1:0] {CH_X, CH_Y, CH_Z, CH_Z2} ch_e;

  typedef enum logic {RUN, HOLD} state_e;

  function automatic ch_e word_ch(input logic [31:0] w);
    return ch_e'(w[CH_MSB:CH_LSB]);
  endfunction

endpackage

// File: rtl/ocra1_sched_fifo.sv
// Synchronous word FIFO with flush; head word is presented combinationally.
module ocra1_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB separates the full and empty cases.
  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ocra1_word_scheduler.sv
// Buffers gradient words and issues them to the OCRA1 serialiser under its timing rules.
// Define OCRA1_SCHED_CONFLICT_EN to stall writes to a channel that is still pending.
module ocra1_word_scheduler
  import ocra1_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    flush_i,
  input  logic                    busy_i,
  output logic [31:0]             data_o,
  output logic                    valid_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    idle_o
`ifdef OCRA1_SCHED_CONFLICT_EN
  ,
  output logic                    conflict_o
`endif
);

  // state | meaning
  // RUN   | issue head word when allowed
  // HOLD  | post-broadcast hold-off, valid_o forced low

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(HOLDOFF);

  logic [31:0]   head_word;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          issue;
  logic          issue_cond;
  logic          head_ok;
  logic          head_bcast;
  logic          fresh_d;
  logic          fresh_q;
  state_e        state_q;
  logic [CW-1:0] hold_cnt_q;

  assign in_ready_o = ~fifo_full & ~rst;
  assign push       = in_valid_i & in_ready_o & ~flush_i;

  // A word that becomes head on the edge it was accepted waits one extra cycle.
  assign fresh_d    = push & (level_o == {{(LW-1){1'b0}}, pop});
  assign head_ok    = ~fifo_empty & ~fresh_q;
  assign head_bcast = head_word[BCAST_BIT];

`ifdef OCRA1_SCHED_CONFLICT_EN
  logic [3:0] pending_q;
  ch_e        head_ch;
  assign head_ch    = word_ch(head_word);
  assign issue_cond = ~pending_q[head_ch];
`else
  assign issue_cond = 1'b1;
`endif

  assign issue  = (state_q == RUN) & head_ok & ~flush_i & issue_cond & (~head_bcast | ~busy_i);
  assign pop    = issue;
  assign idle_o = fifo_empty & (state_q == RUN) & ~valid_o;

  ocra1_sched_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush_i),
    .wdata (in_data_i),
    .rdata (head_word),
    .level (level_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      hold_cnt_q <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      fresh_q    <= 1'b0;
`ifdef OCRA1_SCHED_CONFLICT_EN
      pending_q  <= '0;
      conflict_o <= 1'b0;
`endif
    end else begin
      valid_o <= issue;
      fresh_q <= fresh_d;
      if (issue)
        data_o <= head_word;

      case (state_q)
        RUN: begin
          if (issue && head_bcast) begin
            state_q    <= HOLD;
            hold_cnt_q <= CW'(HOLDOFF - 1);
          end
        end
        HOLD: begin
          // Counter keeps running through a flush; the serialiser is mid-accept.
          if (hold_cnt_q == '0)
            state_q <= RUN;
          else
            hold_cnt_q <= hold_cnt_q - 1'b1;
        end
        default: state_q <= RUN;
      endcase

`ifdef OCRA1_SCHED_CONFLICT_EN
      conflict_o <= (state_q == RUN) & head_ok & ~flush_i & ~issue_cond;
      if (flush_i)
        pending_q <= '0;
      else if (issue) begin
        if (head_bcast)
          pending_q <= '0;
        else
          pending_q[head_ch] <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ocra1_word_scheduler.sv
// Randomised and directed bench for ocra1_word_scheduler against a queue-based reference model.
module tb_ocra1_word_scheduler;

  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 4;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   in_data_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic          flush_i = 1'b0;
  logic          busy_i = 1'b0;
  logic [31:0]   data_o;
  logic          valid_o;
  logic [LW-1:0] level_o;
  logic          idle_o;
`ifdef OCRA1_SCHED_CONFLICT_EN
  logic          conflict_o;
`endif

  ocra1_word_scheduler #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .flush_i    (flush_i),
    .busy_i     (busy_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .level_o    (level_o),
    .idle_o     (idle_o)
`ifdef OCRA1_SCHED_CONFLICT_EN
    ,
    .conflict_o (conflict_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of words stamped with their acceptance edge.
  typedef struct {
    logic [31:0] w;
    int          ts;
  } ent_t;

  ent_t        mq[$];
  int          edge_n    = 0;
  int          hold_left = 0;
  logic        m_valid   = 1'b0;
  logic [31:0] m_data    = '0;
  logic [3:0]  m_pend    = '0;
  logic        m_conf    = 1'b0;

  int          iss_edge[$];
  logic [31:0] iss_data[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    hold_left = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_pend    = '0;
    m_conf    = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [31:0] d, input logic b, input logic f);
    bit   can_push, eligible, cond, bc;
    int   ch;
    ent_t e;
    can_push = v && (mq.size() < DEPTH);
    eligible = (hold_left == 0) && (mq.size() > 0);
    if (eligible) eligible = (mq[0].ts + 2 <= edge_n);
    bc   = eligible ? mq[0].w[24] : 1'b0;
    ch   = eligible ? int'(mq[0].w[26:25]) : 0;
    cond = 1'b1;
`ifdef OCRA1_SCHED_CONFLICT_EN
    if (eligible) cond = !m_pend[ch];
`endif
    m_conf = eligible && !f && !cond;
    if (hold_left > 0) hold_left--;
    m_valid = 1'b0;
    if (f) begin
      mq.delete();
      m_pend = '0;
    end else if (eligible && cond && !(bc && b)) begin
      e       = mq.pop_front();
      m_valid = 1'b1;
      m_data  = e.w;
      if (bc) begin
        hold_left = HOLDOFF;
        m_pend    = '0;
      end else begin
        m_pend[ch] = 1'b1;
      end
    end
    if (can_push && !f) mq.push_back('{w: d, ts: edge_n});
    edge_n++;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic b, input logic f);
    in_valid_i = v;
    in_data_i  = d;
    busy_i     = b;
    flush_i    = f;
    #1;
    chk("ready", {31'd0, in_ready_o}, {31'd0, mq.size() < DEPTH});
    @(posedge clk);
    model_edge(v, d, b, f);
    @(negedge clk);
    chk("valid", {31'd0, valid_o}, {31'd0, m_valid});
    chk("data", data_o, m_data);
    chk("level", {{(32-LW){1'b0}}, level_o}, mq.size());
    chk("idle", {31'd0, idle_o}, {31'd0, (mq.size() == 0) && (hold_left == 0) && !m_valid});
`ifdef OCRA1_SCHED_CONFLICT_EN
    chk("conflict", {31'd0, conflict_o}, {31'd0, m_conf});
`endif
    if (valid_o) begin
      iss_edge.push_back(edge_n - 1);
      iss_data.push_back(data_o);
    end
  endtask

  task automatic idle_steps(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, b, 1'b0);
  endtask

  task automatic clr_log();
    iss_edge.delete();
    iss_data.delete();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    logic [31:0] w;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_level", {{(32-LW){1'b0}}, level_o}, 32'd0);
    chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_idle", {31'd0, idle_o}, 32'd1);
    rst = 1'b0;
    model_reset();

    // Three consecutive channel writes
    clr_log();
    p = edge_n;
    step(1'b1, 32'h0000_0100, 1'b0, 1'b0);
    step(1'b1, 32'h0200_0200, 1'b0, 1'b0);
    step(1'b1, 32'h0400_0300, 1'b0, 1'b0);
    idle_steps(4, 1'b0);
    chk("t1_count", iss_edge.size(), 32'd3);
    if (iss_edge.size() == 3) begin
      chk("t1_edge0", iss_edge[0], p + 2);
      chk("t1_edge2", iss_edge[2], p + 4);
      chk("t1_data0", iss_data[0], 32'h0000_0100);
      chk("t1_data1", iss_data[1], 32'h0200_0200);
      chk("t1_data2", iss_data[2], 32'h0400_0300);
    end

    // Broadcast held off by busy_i
    clr_log();
    step(1'b1, 32'h0100_0055, 1'b1, 1'b0);
    idle_steps(19, 1'b1);
    chk("t2_no_early", iss_edge.size(), 32'd0);
    p = edge_n;
    step(1'b0, 32'd0, 1'b0, 1'b0);
    idle_steps(6, 1'b0);
    chk("t2_count", iss_edge.size(), 32'd1);
    if (iss_edge.size() == 1) chk("t2_edge", iss_edge[0], p);

    // Broadcast then x write: hold-off gap
    clr_log();
    step(1'b1, 32'h0100_0055, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0777, 1'b0, 1'b0);
    idle_steps(9, 1'b0);
    chk("t3_count", iss_edge.size(), 32'd2);
    if (iss_edge.size() == 2) chk("t3_gap", iss_edge[1] - iss_edge[0], HOLDOFF + 1);

    // Fill to full with broadcasts while busy
    for (int i = 0; i < 9; i++) step(1'b1, 32'h0100_0000 | i, 1'b1, 1'b0);
    chk("t4_full_level", {{(32-LW){1'b0}}, level_o}, DEPTH);
    chk("t4_full_ready", {31'd0, in_ready_o}, 32'd0);
    step(1'b1, 32'h0100_0008, 1'b0, 1'b0);
    chk("t4_pop_level", {{(32-LW){1'b0}}, level_o}, DEPTH - 1);
    step(1'b1, 32'h0100_0008, 1'b1, 1'b0);
    chk("t4_refill_level", {{(32-LW){1'b0}}, level_o}, DEPTH);
    idle_steps(50, 1'b0);

    // Flush during HOLD with five words queued
    for (int i = 0; i < 6; i++) step(1'b1, 32'h0100_0010 | i, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("t5_pre_level", {{(32-LW){1'b0}}, level_o}, 32'd5);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t5_flush_level", {{(32-LW){1'b0}}, level_o}, 32'd0);
    chk("t5_hold_idle", {31'd0, idle_o}, 32'd0);
    idle_steps(2, 1'b0);
    chk("t5_still_hold", {31'd0, idle_o}, 32'd0);
    idle_steps(1, 1'b0);
    chk("t5_idle", {31'd0, idle_o}, 32'd1);

    // Reset mid-HOLD; next broadcast still waits for busy low
    step(1'b1, 32'h0100_0099, 1'b0, 1'b0);
    idle_steps(3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t6_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("t6_rst_idle", {31'd0, idle_o}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    clr_log();
    step(1'b1, 32'h0100_00aa, 1'b1, 1'b0);
    idle_steps(6, 1'b1);
    chk("t6_bcast_wait", iss_edge.size(), 32'd0);
    idle_steps(8, 1'b0);
    chk("t6_bcast_issued", iss_edge.size(), 32'd1);

`ifdef OCRA1_SCHED_CONFLICT_EN
    // Second x write stalls behind the pending one; flush recovers
    step(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    step(1'b1, 32'h0100_0003, 1'b0, 1'b0);
    idle_steps(10, 1'b0);
    chk("c1_conflict", {31'd0, conflict_o}, 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    idle_steps(2, 1'b0);
    chk("c1_idle", {31'd0, idle_o}, 32'd1);
    clr_log();
    step(1'b1, 32'h0000_0011, 1'b0, 1'b0);
    step(1'b1, 32'h0300_0012, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    idle_steps(10, 1'b0);
    chk("c2_count", iss_edge.size(), 32'd3);
`endif

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      w       = $urandom;
      w[24]   = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 2) != 0), w, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 39) == 0));
    end
    step(1'b0, 32'd0, 1'b0, 1'b1);
    idle_steps(8, 1'b0);
    chk("rand_end_idle", {31'd0, idle_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
